// File: rtl/wbit_serializer.sv
// rtl/wbit_serializer.sv - bit-serial weight transmitter for the SMAC array
//
// Accepts parallel weight words (N_LANES lanes of Pw bits) over a
// valid/ready handshake and shifts P bits of each lane out one bit per
// cycle, P = 4/6/8 latched per word from par_sel_Pw. One shift register
// holds the active word and one holding buffer queues the next, so
// back-to-back words stream without a bubble.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   par_sel_Pw    precision select (00:4, 01:6, 1x:8 bits)
//   w_in          parallel weights, lane k at [k*Pw +: Pw]
//   w_valid       w_in valid
//   w_ready       serializer can accept a word (registered)
//   w_stall       downstream hold, freezes shifting
//   w_bits        current serial bit of each lane
//   w_cnt         one pulse per valid bit on w_bits
//   bit_first     w_bits is the first bit of a word
//   bit_last      w_bits is the last bit of a word
//   cnt_clear     resynchronizes downstream bit counters before a new stream
//   busy          a word is in flight or buffered
//
// Optional feature: define WBIT_SER_MSB_FIRST_EN to send MSB first.

module wbit_serializer #(
   parameter int Pw      = 8,
   parameter int N_LANES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              par_sel_Pw,
   input  logic [N_LANES*Pw-1:0]   w_in,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic                    w_stall,
   output logic [N_LANES-1:0]      w_bits,
   output logic                    w_cnt,
   output logic                    bit_first,
   output logic                    bit_last,
   output logic                    cnt_clear,
   output logic                    busy
);

   localparam int W  = N_LANES * Pw;
   localparam int IW = $clog2(Pw + 1);
   localparam int LW = $clog2(Pw);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                r_state;
   logic [W-1:0]          r_shift;
   logic [W-1:0]          r_hold;
   logic [IW-1:0]         r_p;
   logic [IW-1:0]         r_hold_p;
   logic [IW-1:0]         r_idx;
   logic                  r_done;
   logic                  r_hold_full;
   logic                  r_w_ready;
   logic                  r_busy;
   logic                  r_cnt_clear;
   logic                  r_w_cnt;
   logic                  r_first;
   logic                  r_last;
   logic [N_LANES-1:0]    r_bits;

   logic [IW-1:0]         w_in_p;
   logic                  w_accept;
   logic                  w_adv;
   logic                  w_present;
   logic                  w_direct;
   logic                  w_to_idle;
   logic                  w_hold_load;
   logic                  w_hold_free;
   logic                  w_hold_full_nxt;
   state_t                w_state_nxt;
   logic [W-1:0]          w_src_word;
   logic [IW-1:0]         w_src_p;
   logic [IW-1:0]         w_src_idx;
   logic [LW-1:0]         w_pos;
   logic [N_LANES-1:0][Pw-1:0] w_lanes;
   logic [N_LANES-1:0]    w_bits_nxt;

   always_comb begin
      case (par_sel_Pw)
         2'b00:   w_in_p = IW'(4);
         2'b01:   w_in_p = IW'(6);
         default: w_in_p = IW'(8);
      endcase
   end

   assign w_accept = w_valid && r_w_ready;
   assign w_adv    = (r_state == SHIFT) && !w_stall;

   // r_done means the last bit of the shift word is already on w_bits; the
   // next advancing cycle presents bit 0 of whichever word follows.
   assign w_present   = w_adv && (!r_done || r_hold_full || w_accept);
   assign w_direct    = w_adv && r_done && !r_hold_full && w_accept;
   assign w_to_idle   = w_adv && r_done && !r_hold_full && !w_accept;
   assign w_hold_load = w_accept && (r_state == SHIFT) && !w_direct;
   assign w_hold_free = w_present && r_done && r_hold_full;

   // Load and free are exclusive: an accept needs w_ready, i.e. an empty buffer.
   assign w_hold_full_nxt = w_hold_load ? 1'b1 : (w_hold_free ? 1'b0 : r_hold_full);

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == IDLE && w_accept)
         w_state_nxt = SHIFT;
      else if (w_to_idle)
         w_state_nxt = IDLE;
   end

   // Source of the bit presented this cycle: the running word, or bit 0 of
   // the buffered / just-accepted word when the running one has finished.
   always_comb begin
      w_src_word = r_shift;
      w_src_p    = r_p;
      w_src_idx  = r_idx;
      if (r_done) begin
         w_src_idx = '0;
         if (r_hold_full) begin
            w_src_word = r_hold;
            w_src_p    = r_hold_p;
         end else begin
            w_src_word = w_in;
            w_src_p    = w_in_p;
         end
      end
   end

`ifdef WBIT_SER_MSB_FIRST_EN
   assign w_pos = LW'(w_src_p - IW'(1) - w_src_idx);
`else
   assign w_pos = LW'(w_src_idx);
`endif

   assign w_lanes = w_src_word;

   always_comb begin
      w_bits_nxt = '0;
      for (int k = 0; k < N_LANES; k++)
         w_bits_nxt[k] = w_lanes[k][w_pos];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_hold      <= '0;
         r_p         <= '0;
         r_hold_p    <= '0;
         r_idx       <= '0;
         r_done      <= 1'b0;
         r_hold_full <= 1'b0;
         r_w_ready   <= 1'b1;
         r_busy      <= 1'b0;
         r_cnt_clear <= 1'b0;
         r_w_cnt     <= 1'b0;
         r_first     <= 1'b0;
         r_last      <= 1'b0;
         r_bits      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_w_ready   <= !w_hold_full_nxt;
         r_busy      <= (w_state_nxt == SHIFT) || w_hold_full_nxt;
         r_cnt_clear <= (r_state == IDLE) && w_accept;
         r_w_cnt     <= w_present;
         r_first     <= w_present && (w_src_idx == '0);
         r_last      <= w_present && (w_src_idx == w_src_p - IW'(1));

         if (w_hold_load) begin
            r_hold   <= w_in;
            r_hold_p <= w_in_p;
         end

         if (r_state == IDLE && w_accept) begin
            r_shift <= w_in;
            r_p     <= w_in_p;
            r_idx   <= '0;
            r_done  <= 1'b0;
         end else if (w_present) begin
            r_bits  <= w_bits_nxt;
            r_shift <= w_src_word;
            r_p     <= w_src_p;
            r_idx   <= w_src_idx + IW'(1);
            r_done  <= (w_src_idx == w_src_p - IW'(1));
         end else if (w_to_idle) begin
            r_done  <= 1'b0;
         end
      end
   end

   assign w_ready   = r_w_ready;
   assign busy      = r_busy;
   assign cnt_clear = r_cnt_clear;
   assign w_cnt     = r_w_cnt;
   assign bit_first = r_first;
   assign bit_last  = r_last;
   assign w_bits    = r_bits;

endmodule

// File: tb/tb_wbit_serializer.sv
// tb/tb_wbit_serializer.sv - self-checking bench for wbit_serializer

module tb_wbit_serializer;

   localparam int PW = 8;
   localparam int NL = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      par_sel = 2'b00;
   logic [31:0]     w_in = '0;
   logic            w_valid = 1'b0;
   logic            w_ready;
   logic            w_stall = 1'b0;
   logic [NL-1:0]   w_bits;
   logic            w_cnt;
   logic            bit_first;
   logic            bit_last;
   logic            cnt_clear;
   logic            busy;

   wbit_serializer #(.Pw(PW), .N_LANES(NL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .par_sel_Pw (par_sel),
      .w_in       (w_in),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_stall    (w_stall),
      .w_bits     (w_bits),
      .w_cnt      (w_cnt),
      .bit_first  (bit_first),
      .bit_last   (bit_last),
      .cnt_clear  (cnt_clear),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NL-1:0] bits;
      logic          first;
      logic          last;
   } exp_t;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] word;
      int          exp_p;
   } vec_t;

   exp_t q[$];
   exp_t e;
   int   n_pass = 0;
   int   n_total = 0;
   int   n_cnt = 0;
   int   n_clr = 0;
   int   run = 0;
   int   max_run = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int bitpos(input int i, input int p);
`ifdef WBIT_SER_MSB_FIRST_EN
      return p - 1 - i;
`else
      return i;
`endif
   endfunction

   function automatic void push_word(input logic [31:0] w, input int p);
      exp_t x;
      for (int i = 0; i < p; i++) begin
         for (int k = 0; k < NL; k++) x.bits[k] = w[k*PW + bitpos(i, p)];
         x.first = (i == 0);
         x.last  = (i == p - 1);
         q.push_back(x);
      end
   endfunction

   // Scoreboard: every w_cnt pulse must match the oldest expected bit.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cnt_clear) n_clr++;
         if (w_cnt) begin
            n_cnt++;
            run++;
            if (run > max_run) max_run = run;
            check("sb_queue_nonempty", (q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               check("sb_bits", 32'(w_bits), 32'(e.bits));
               check("sb_first", 32'(bit_first), 32'(e.first));
               check("sb_last", 32'(bit_last), 32'(e.last));
            end
         end else begin
            run = 0;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [1:0] sel, input logic [31:0] w, input int p);
      int n = 0;
      par_sel = sel;
      w_in    = w;
      w_valid = 1'b1;
      while (!w_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 32'(w_ready), 32'd1);
      if (w_ready) begin
         @(posedge clk);
         push_word(w, p);
         @(negedge clk);
      end
      w_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy || q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_idle", (busy || q.size() != 0) ? 32'd1 : 32'd0, 32'd0);
   endtask

   task automatic clr_stats();
      n_cnt = 0;
      n_clr = 0;
      max_run = 0;
   endtask

   vec_t vecs[4];
   logic [NL-1:0] held;
   int n;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{2'b10, 32'h3C817EA5, 8};
      vecs[1] = '{2'b00, 32'hF5A9E673, 4};
      vecs[2] = '{2'b01, 32'h2A15C021, 6};
      vecs[3] = '{2'b11, 32'h8001FF5A, 8};

      repeat (3) @(negedge clk);
      check("rst_w_ready", 32'(w_ready), 32'd1);
      check("rst_w_bits", 32'(w_bits), 32'd0);
      check("rst_flags", {27'd0, w_cnt, bit_first, bit_last, cnt_clear, busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Latency: cnt_clear one cycle after accept, first bit one cycle later.
      clr_stats();
      send(2'b10, 32'h000000A5, 8);
      check("lat_cnt_clear", 32'(cnt_clear), 32'd1);
      check("lat_no_cnt", 32'(w_cnt), 32'd0);
      @(negedge clk);
      check("lat_first_cnt", 32'(w_cnt), 32'd1);
      check("lat_first_flag", 32'(bit_first), 32'd1);
      wait_idle();
      check("a5_bits", n_cnt, 8);

      for (int v = 0; v < 4; v++) begin
         clr_stats();
         send(vecs[v].sel, vecs[v].word, vecs[v].exp_p);
         wait_idle();
         check("vec_bitcount", n_cnt, vecs[v].exp_p);
         check("vec_clear", n_clr, 1);
      end

      // Back-to-back 4-bit words stream contiguously with a single clear.
      clr_stats();
      send(2'b00, 32'h30A05013, 4);
      send(2'b00, 32'h0C07090C, 4);
      wait_idle();
      check("b2b_bits", n_cnt, 8);
      check("b2b_run", max_run, 8);
      check("b2b_clear", n_clr, 1);

      // Precision change in flight does not affect the current word.
      clr_stats();
      send(2'b01, 32'h15260B21, 6);
      repeat (2) @(negedge clk);
      par_sel = 2'b10;
      wait_idle();
      check("psel_change_bits", n_cnt, 6);

      // Continuous valid: ready drops after second accept, returns after bit 7.
      clr_stats();
      send(2'b10, 32'h11223344, 8);
      send(2'b10, 32'h55667788, 8);
      check("cont_ready_low", 32'(w_ready), 32'd0);
      par_sel = 2'b10;
      w_in    = 32'h99AABBCC;
      w_valid = 1'b1;
      n = 0;
      while (!w_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cont_ready_rise", n, 8);
      send(2'b10, 32'h99AABBCC, 8);
      send(2'b10, 32'hDDEEFF01, 8);
      wait_idle();
      check("cont_bits", n_cnt, 32);
      check("cont_run", max_run, 32);
      check("cont_clear", n_clr, 1);

      // Stall for three cycles while bit 2 is on the lanes.
      clr_stats();
      send(2'b10, 32'h5AC3E71D, 8);
      repeat (3) @(negedge clk);
      for (int k = 0; k < NL; k++) held[k] = vecs[0].word[0];
      begin
         logic [31:0] sw;
         sw = 32'h5AC3E71D;
         for (int k = 0; k < NL; k++) held[k] = sw[k*PW + bitpos(2, 8)];
      end
      w_stall = 1'b1;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check("stall_cnt_low", 32'(w_cnt), 32'd0);
         check("stall_bits_held", 32'(w_bits), 32'(held));
      end
      w_stall = 1'b0;
      wait_idle();
      check("stall_total", n_cnt, 8);

      // Reset in the middle of a word.
      clr_stats();
      send(2'b10, 32'hC3A5F00F, 8);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_ready", 32'(w_ready), 32'd1);
      check("mid_rst_bits", 32'(w_bits), 32'd0);
      check("mid_rst_flags", {27'd0, w_cnt, bit_first, bit_last, cnt_clear, busy}, 32'd0);
      rst_n = 1'b1;
      q.delete();
      @(negedge clk);
      clr_stats();
      send(2'b00, 32'h0A0B0C0D, 4);
      check("post_rst_clear", 32'(cnt_clear), 32'd1);
      wait_idle();
      check("post_rst_bits", n_cnt, 4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
